// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue
// In-order tracker for predicted branches between fetch and execute. Fetch
// pushes {pc, predicted direction}; execute resolves the oldest entry in
// program order. Each resolve produces a one-cycle predictor training write
// on the next cycle. A direction mismatch also raises a mispredict pulse with
// a redirect PC, and discards every younger entry.
// Optional feature: define BRQ_STATS_EN to add saturating resolve/mispredict
// counters (stat_resolved, stat_mispred).
module branch_resolution_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_taken,
    input  logic [PC_W-1:0] res_target,
    output logic            write_enabled,
    output logic            outcome,
    output logic [PC_W-1:0] pc_bits_write,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic            full,
    output logic            empty,
    output logic            underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]     stat_resolved,
    output logic [15:0]     stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointer increment; DEPTH is a power of two so the wrap is free.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    logic [PC_W-1:0]  r_pc    [DEPTH];
    logic             r_taken [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_underflow;
    logic             r_write_enabled;
    logic             r_outcome;
    logic [PC_W-1:0]  r_pc_bits_write;
    logic             r_mispredict;
    logic [PC_W-1:0]  r_redirect_pc;

    logic             w_pop;
    logic             w_flush;
    logic             w_push;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_head_taken;
    logic [PC_W-1:0]  w_redirect_next;
    logic [CNT_W-1:0] w_count_next;

    assign w_head_pc       = r_pc[r_rd_ptr];
    assign w_head_taken    = r_taken[r_rd_ptr];
    assign w_pop           = res_valid && !r_empty;
    assign w_flush         = w_pop && (w_head_taken != res_taken);
    // A pop frees a slot in the same cycle, so a full queue still accepts.
    assign w_push          = pred_valid && (!r_full || w_pop) && !w_flush;
    assign w_redirect_next = res_taken ? res_target : (w_head_pc + PC_W'(4));

    // Next occupancy: a flush empties the queue regardless of push/pop.
    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end else begin
            w_count_next = r_count;
        end
    end

    // Entry storage: write the pushed branch at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_taken[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_pc[r_wr_ptr]    <= pred_pc;
            r_taken[r_wr_ptr] <= pred_taken;
        end
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_flush) begin
                // Tail collapses onto the new head: all younger entries gone.
                r_wr_ptr <= ptr_inc(r_rd_ptr);
            end else if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == CNT_W'(0));
        end
    end

    // Training write, mispredict pulse and redirect, one cycle after the pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write_enabled <= 1'b0;
            r_outcome       <= 1'b0;
            r_pc_bits_write <= '0;
            r_mispredict    <= 1'b0;
            r_redirect_pc   <= '0;
        end else begin
            r_write_enabled <= w_pop;
            r_mispredict    <= w_flush;
            if (w_pop) begin
                r_outcome       <= res_taken;
                r_pc_bits_write <= w_head_pc;
            end
            if (w_flush) begin
                r_redirect_pc <= w_redirect_next;
            end
        end
    end

    // Sticky flag for a resolve arriving with nothing in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_underflow <= 1'b0;
        end else if (res_valid && r_empty) begin
            r_underflow <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    logic [15:0] r_stat_resolved;
    logic [15:0] r_stat_mispred;

    // Saturating counters, updated at the pop edge so they move with write_enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_resolved <= 16'h0000;
            r_stat_mispred  <= 16'h0000;
        end else begin
            if (w_pop && (r_stat_resolved != 16'hFFFF)) begin
                r_stat_resolved <= r_stat_resolved + 16'h0001;
            end
            if (w_flush && (r_stat_mispred != 16'hFFFF)) begin
                r_stat_mispred <= r_stat_mispred + 16'h0001;
            end
        end
    end

    assign stat_resolved = r_stat_resolved;
    assign stat_mispred  = r_stat_mispred;
`endif

    assign write_enabled = r_write_enabled;
    assign outcome       = r_outcome;
    assign pc_bits_write = r_pc_bits_write;
    assign mispredict    = r_mispredict;
    assign redirect_pc   = r_redirect_pc;
    assign full          = r_full;
    assign empty         = r_empty;
    assign underflow     = r_underflow;

endmodule
